// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code byte stream to key events: prefix FSM, shift/caps tracking,
// ASCII translation, held-key tracking and typematic-aware press counting.
module ps2_key_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_code,
   output logic       ev_valid,
   output logic       ev_make,
   output logic       ev_ext,
   output logic       ev_repeat,
   output logic [7:0] ev_code,
   output logic [7:0] ev_ascii,
   output logic       held,
   output logic [8:0] held_code,
   output logic       shift,
   output logic       caps,
   output logic [7:0] press_cnt
);

   localparam int unsigned CODE_W = 8;
   localparam int unsigned KEY_W  = CODE_W + 1;

   localparam logic [CODE_W-1:0] CODE_EXT     = 8'hE0;
   localparam logic [CODE_W-1:0] CODE_BRK     = 8'hF0;
   localparam logic [CODE_W-1:0] CODE_BAT     = 8'hAA;
   localparam logic [CODE_W-1:0] CODE_ACK     = 8'hFA;
   localparam logic [CODE_W-1:0] CODE_PAUSE   = 8'hE1;
   localparam logic [CODE_W-1:0] CODE_LSHIFT  = 8'h12;
   localparam logic [CODE_W-1:0] CODE_RSHIFT  = 8'h59;
   localparam logic [CODE_W-1:0] CODE_CAPS    = 8'h58;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                ev_valid_q, ev_valid_d;
   logic                ev_make_q, ev_make_d;
   logic                ev_ext_q, ev_ext_d;
   logic                ev_repeat_q, ev_repeat_d;
   logic [CODE_W-1:0]   ev_code_q, ev_code_d;
   logic [CODE_W-1:0]   ev_ascii_q, ev_ascii_d;
   logic                held_q, held_d;
   logic [KEY_W-1:0]    held_code_q, held_code_d;
   logic                shift_l_q, shift_l_d;
   logic                shift_r_q, shift_r_d;
   logic                caps_q, caps_d;
   logic [CODE_W-1:0]   press_cnt_q, press_cnt_d;

   logic                fire;
   logic                fire_make;
   logic                fire_ext;
   logic [KEY_W-1:0]    key;
   logic                key_match;

   // Lowercase letters/digits/whitespace; letters lifted to uppercase when upper is set.
   function automatic logic [CODE_W-1:0] to_ascii(input logic [CODE_W-1:0] code,
                                                  input logic upper);
      logic [CODE_W-1:0] a;
      logic              letter;
      a      = 8'h00;
      letter = 1'b1;
      case (code)
         8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
         8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
         8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
         8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
         8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
         default: begin
            letter = 1'b0;
            case (code)
               8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;  8'h25: a = 8'h34;
               8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;  8'h3E: a = 8'h38;
               8'h46: a = 8'h39;  8'h45: a = 8'h30;
               8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
               default: a = 8'h00;
            endcase
         end
      endcase
      if (letter && upper) a = a - 8'h20;
      return a;
   endfunction

   // Prefix FSM: decide whether this byte completes an event and of which kind.
   always_comb begin
      state_d   = state_q;
      fire      = 1'b0;
      fire_make = 1'b0;
      fire_ext  = 1'b0;
      if (in_valid) begin
         case (state_q)
            S_IDLE: begin
               if (in_code == CODE_EXT)      state_d = S_EXT;
               else if (in_code == CODE_BRK) state_d = S_BRK;
               else if (in_code != CODE_BAT && in_code != CODE_ACK && in_code != CODE_PAUSE) begin
                  fire      = 1'b1;
                  fire_make = 1'b1;
               end
            end
            S_EXT: begin
               if (in_code == CODE_BRK)      state_d = S_EXT_BRK;
               else if (in_code != CODE_EXT) begin
                  fire      = 1'b1;
                  fire_make = 1'b1;
                  fire_ext  = 1'b1;
                  state_d   = S_IDLE;
               end
            end
            S_BRK: begin
               if (in_code == CODE_EXT)      state_d = S_EXT_BRK;
               else if (in_code != CODE_BRK) begin
                  fire    = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: begin
               if (in_code != CODE_EXT && in_code != CODE_BRK) begin
                  fire     = 1'b1;
                  fire_ext = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         endcase
      end
   end

   assign key       = {fire_ext, in_code};
   assign key_match = held_q && (held_code_q == key);

   // Event payload and key-state bookkeeping; shift/caps sampled before this byte.
   always_comb begin
      ev_valid_d  = 1'b0;
      ev_make_d   = ev_make_q;
      ev_ext_d    = ev_ext_q;
      ev_repeat_d = ev_repeat_q;
      ev_code_d   = ev_code_q;
      ev_ascii_d  = ev_ascii_q;
      held_d      = held_q;
      held_code_d = held_code_q;
      shift_l_d   = shift_l_q;
      shift_r_d   = shift_r_q;
      caps_d      = caps_q;
      press_cnt_d = press_cnt_q;
      if (fire) begin
         ev_valid_d = 1'b1;
         ev_make_d  = fire_make;
         ev_ext_d   = fire_ext;
         ev_code_d  = in_code;
         if (fire_make) begin
            ev_repeat_d = key_match;
            ev_ascii_d  = fire_ext ? 8'h00
                                   : to_ascii(in_code, (shift_l_q | shift_r_q) ^ caps_q);
            if (!key_match) begin
               press_cnt_d = press_cnt_q + 8'd1;
               held_d      = 1'b1;
               held_code_d = key;
               if (!fire_ext && in_code == CODE_CAPS) caps_d = ~caps_q;
            end
            if (!fire_ext && in_code == CODE_LSHIFT) shift_l_d = 1'b1;
            if (!fire_ext && in_code == CODE_RSHIFT) shift_r_d = 1'b1;
         end else begin
            ev_repeat_d = 1'b0;
            ev_ascii_d  = 8'h00;
            if (key_match) held_d = 1'b0;
            if (!fire_ext && in_code == CODE_LSHIFT) shift_l_d = 1'b0;
            if (!fire_ext && in_code == CODE_RSHIFT) shift_r_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ev_valid_q  <= 1'b0;
         ev_make_q   <= 1'b0;
         ev_ext_q    <= 1'b0;
         ev_repeat_q <= 1'b0;
         ev_code_q   <= '0;
         ev_ascii_q  <= '0;
         held_q      <= 1'b0;
         held_code_q <= '0;
         shift_l_q   <= 1'b0;
         shift_r_q   <= 1'b0;
         caps_q      <= 1'b0;
         press_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ev_valid_q  <= ev_valid_d;
         ev_make_q   <= ev_make_d;
         ev_ext_q    <= ev_ext_d;
         ev_repeat_q <= ev_repeat_d;
         ev_code_q   <= ev_code_d;
         ev_ascii_q  <= ev_ascii_d;
         held_q      <= held_d;
         held_code_q <= held_code_d;
         shift_l_q   <= shift_l_d;
         shift_r_q   <= shift_r_d;
         caps_q      <= caps_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   assign ev_valid  = ev_valid_q;
   assign ev_make   = ev_make_q;
   assign ev_ext    = ev_ext_q;
   assign ev_repeat = ev_repeat_q;
   assign ev_code   = ev_code_q;
   assign ev_ascii  = ev_ascii_q;
   assign held      = held_q;
   assign held_code = held_code_q;
   assign shift     = shift_l_q | shift_r_q;
   assign caps      = caps_q;
   assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: scan-code sequences with hand-computed event expectations.
module tb_ps2_key_decoder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_code;
   logic       ev_valid, ev_make, ev_ext, ev_repeat;
   logic [7:0] ev_code, ev_ascii;
   logic       held;
   logic [8:0] held_code;
   logic       shift, caps;
   logic [7:0] press_cnt;

   int checks = 0;
   int errors = 0;
   int ev_seen = 0;

   ps2_key_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_code   (in_code),
      .ev_valid  (ev_valid),
      .ev_make   (ev_make),
      .ev_ext    (ev_ext),
      .ev_repeat (ev_repeat),
      .ev_code   (ev_code),
      .ev_ascii  (ev_ascii),
      .held      (held),
      .held_code (held_code),
      .shift     (shift),
      .caps      (caps),
      .press_cnt (press_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one input for one full cycle; returns at the following negedge.
   task automatic drive(input logic v, input logic [7:0] code);
      in_valid = v;
      in_code  = code;
      @(negedge clk);
      if (ev_valid === 1'b1) ev_seen++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 8'h00);
      drive(1'b0, 8'h00);
      rst = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"},  32'(ev_valid),  32'h0);
      chk({tag, "_make"},   32'(ev_make),   32'h0);
      chk({tag, "_ext"},    32'(ev_ext),    32'h0);
      chk({tag, "_repeat"}, 32'(ev_repeat), 32'h0);
      chk({tag, "_code"},   32'(ev_code),   32'h0);
      chk({tag, "_ascii"},  32'(ev_ascii),  32'h0);
      chk({tag, "_held"},   32'(held),      32'h0);
      chk({tag, "_hcode"},  32'(held_code), 32'h0);
      chk({tag, "_shift"},  32'(shift),     32'h0);
      chk({tag, "_caps"},   32'(caps),      32'h0);
      chk({tag, "_cnt"},    32'(press_cnt), 32'h0);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_code  = 8'h00;
      @(negedge clk);
      do_reset();
      chk_zero("rst");

      // Single press/release of A
      ev_seen = 0;
      drive(1'b1, 8'h1C);
      chk("a_mk_valid", 32'(ev_valid), 32'h1);
      chk("a_mk_make",  32'(ev_make),  32'h1);
      chk("a_mk_ext",   32'(ev_ext),   32'h0);
      chk("a_mk_rep",   32'(ev_repeat), 32'h0);
      chk("a_mk_code",  32'(ev_code),  32'h1C);
      chk("a_mk_ascii", 32'(ev_ascii), 32'h61);
      chk("a_mk_cnt",   32'(press_cnt), 32'h1);
      chk("a_mk_held",  32'(held),     32'h1);
      chk("a_mk_hcode", 32'(held_code), 32'h01C);
      drive(1'b1, 8'hF0);
      chk("a_f0_valid", 32'(ev_valid), 32'h0);
      drive(1'b1, 8'h1C);
      chk("a_br_valid", 32'(ev_valid), 32'h1);
      chk("a_br_make",  32'(ev_make),  32'h0);
      chk("a_br_ascii", 32'(ev_ascii), 32'h0);
      chk("a_br_held",  32'(held),     32'h0);
      drive(1'b0, 8'h00);
      chk("a_idle_valid", 32'(ev_valid), 32'h0);
      chk("a_hold_code",  32'(ev_code),  32'h1C);
      chk("a_ev_count",   32'(ev_seen),  32'h2);

      // Shift + A with typematic repeat
      do_reset();
      drive(1'b1, 8'h12);
      chk("sh_mk_shift", 32'(shift), 32'h1);
      chk("sh_mk_ascii", 32'(ev_ascii), 32'h0);
      drive(1'b1, 8'h1C);
      chk("sa_ascii", 32'(ev_ascii), 32'h41);
      chk("sa_rep",   32'(ev_repeat), 32'h0);
      drive(1'b1, 8'h1C);
      chk("sa_rep2",  32'(ev_repeat), 32'h1);
      chk("sa_valid2", 32'(ev_valid), 32'h1);
      chk("sa_cnt",   32'(press_cnt), 32'h2);
      drive(1'b1, 8'hF0);
      drive(1'b1, 8'h1C);
      chk("sa_br_held", 32'(held), 32'h0);
      drive(1'b1, 8'hF0);
      drive(1'b1, 8'h12);
      chk("sh_br_shift", 32'(shift), 32'h0);
      chk("sh_br_held",  32'(held),  32'h0);
      chk("sh_br_cnt",   32'(press_cnt), 32'h2);

      // Caps Lock interplay with Shift
      do_reset();
      drive(1'b1, 8'h58);
      chk("caps_on", 32'(caps), 32'h1);
      drive(1'b1, 8'hF0);
      drive(1'b1, 8'h58);
      chk("caps_keep", 32'(caps), 32'h1);
      drive(1'b1, 8'h1C);
      chk("caps_ascii", 32'(ev_ascii), 32'h41);
      drive(1'b1, 8'h12);
      chk("caps_shift", 32'(shift), 32'h1);
      drive(1'b1, 8'h1C);
      chk("caps_sh_ascii", 32'(ev_ascii), 32'h61);
      drive(1'b1, 8'h16);
      chk("digit_shift_ascii", 32'(ev_ascii), 32'h31);
      drive(1'b1, 8'h5A);
      chk("enter_ascii", 32'(ev_ascii), 32'h0D);
      drive(1'b1, 8'h0E);
      chk("unmapped_ascii", 32'(ev_ascii), 32'h0);

      // Extended key make/break
      do_reset();
      ev_seen = 0;
      drive(1'b1, 8'hE0);
      chk("ext_pre_valid", 32'(ev_valid), 32'h0);
      drive(1'b1, 8'h75);
      chk("ext_mk_valid", 32'(ev_valid), 32'h1);
      chk("ext_mk_ext",   32'(ev_ext),   32'h1);
      chk("ext_mk_make",  32'(ev_make),  32'h1);
      chk("ext_mk_code",  32'(ev_code),  32'h75);
      chk("ext_mk_ascii", 32'(ev_ascii), 32'h0);
      chk("ext_mk_hcode", 32'(held_code), 32'h175);
      drive(1'b1, 8'hE0);
      chk("ext_pre2_valid", 32'(ev_valid), 32'h0);
      drive(1'b1, 8'hF0);
      chk("ext_pre3_valid", 32'(ev_valid), 32'h0);
      drive(1'b1, 8'h75);
      chk("ext_br_make", 32'(ev_make), 32'h0);
      chk("ext_br_ext",  32'(ev_ext),  32'h1);
      chk("ext_br_held", 32'(held),    32'h0);
      drive(1'b0, 8'h00);
      chk("ext_ev_count", 32'(ev_seen), 32'h2);

      // Back-to-back bytes with reset mid-prefix
      do_reset();
      drive(1'b1, 8'hAA);
      chk("bb_aa_valid", 32'(ev_valid), 32'h0);
      drive(1'b1, 8'hFA);
      chk("bb_fa_valid", 32'(ev_valid), 32'h0);
      drive(1'b1, 8'h16);
      chk("bb_16_valid", 32'(ev_valid), 32'h1);
      chk("bb_16_ascii", 32'(ev_ascii), 32'h31);
      chk("bb_16_cnt",   32'(press_cnt), 32'h1);
      drive(1'b1, 8'hE0);
      chk("bb_e0_valid", 32'(ev_valid), 32'h0);
      rst = 1'b1;
      drive(1'b1, 8'h16);
      rst = 1'b0;
      chk_zero("bb_rst");
      drive(1'b1, 8'h16);
      chk("bb_post_valid", 32'(ev_valid), 32'h1);
      chk("bb_post_ext",   32'(ev_ext),   32'h0);
      chk("bb_post_cnt",   32'(press_cnt), 32'h1);
      chk("bb_post_hcode", 32'(held_code), 32'h016);
      drive(1'b0, 8'h00);

      // Press counter wrap over 256 non-repeat space presses
      do_reset();
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 8'h29);
         chk("wrap_ascii", 32'(ev_ascii), 32'h20);
         chk("wrap_cnt",   32'(press_cnt), 32'((i + 1) % 256));
         drive(1'b1, 8'hF0);
         drive(1'b1, 8'h29);
      end
      chk("wrap_final", 32'(press_cnt), 32'h0);
      chk("wrap_held",  32'(held),      32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the byte stream from the PS/2 receiver (one strobe per validated scan-code byte) and turns it into key events. Resolves the 0xE0 extended and 0xF0 break prefixes, tracks Shift and Caps Lock, translates make codes to ASCII, suppresses typematic repeats in the press counter, and exposes the currently held key. Sits between the PS/2 receiver and the display/console logic in npc.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle strobe: in_code holds a received byte
- in_code  in  8  raw scan-code byte
- ev_valid  out  1  one-cycle strobe: event fields valid
- ev_make  out  1  1 = make (press), 0 = break (release)
- ev_ext  out  1  event was 0xE0-prefixed
- ev_repeat  out  1  make of the key already held (typematic)
- ev_code  out  8  scan code, without prefixes
- ev_ascii  out  8  ASCII for make events; 0x00 for break, extended, or unmapped
- held  out  1  a key is currently held
- held_code  out  9  {ext, code} of the held key
- shift  out  1  left (0x12) or right (0x59) Shift currently down
- caps  out  1  Caps Lock toggle state
- press_cnt  out  8  count of non-repeat make events; wraps 255 -> 0

## Operation
- Prefix FSM states: IDLE, EXT (seen E0), BRK (seen F0), EXT_BRK (seen E0 F0). Transitions occur only on in_valid.
- IDLE: E0 -> EXT; F0 -> BRK; 0xAA, 0xFA, 0xE1 -> ignored, stay IDLE; any other byte -> make event (ext=0), stay IDLE.
- EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> make event (ext=1) -> IDLE.
- BRK: other byte -> break event (ext=0) -> IDLE; F0 -> stay BRK; E0 -> EXT_BRK.
- EXT_BRK: other byte -> break event (ext=1) -> IDLE; E0/F0 -> stay.
- Make event:
  - ev_repeat = held && held_code == {ext, code}.
  - If not a repeat: press_cnt += 1; held <= 1; held_code <= {ext, code}.
  - Caps toggles on a non-repeat, non-ext make of 0x58.
  - Shift bits set on a non-ext make of 0x12 / 0x59.
- Break event:
  - Non-ext 0x12 / 0x59 clears the corresponding shift bit.
  - If held && held_code == {ext, code}, then held <= 0; otherwise held is unchanged.
- ASCII applies to non-ext makes only; it uses the shift/caps values before the current byte is applied.
  - Letters, lowercase by default, uppercase when shift XOR caps: A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A.
  - Digits, unaffected by Shift: 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46 0=45.
  - Space 29 -> 0x20; Enter 5A -> 0x0D; Backspace 66 -> 0x08.
  - Everything else -> 0x00.

## Timing
- Reset: FSM = IDLE; ev_valid, ev_make, ev_ext, ev_repeat, held, shift, caps = 0; ev_code, ev_ascii, held_code, press_cnt = 0.
- Latency: ev_* are registered. ev_valid is high exactly in the cycle after the in_valid cycle carrying the final byte, for one cycle.
- ev_* fields hold their values until the next event.
- held, held_code, shift, caps, and press_cnt update on the same edge that raises ev_valid.
- in_valid may be asserted every cycle; each byte is consumed. There is no back-pressure.
- Prefix bytes and ignored bytes produce no ev_valid.
- rst overrides in_valid in the same cycle. A reset mid-sequence (e.g. after E0) discards the prefix; the next plain byte is a non-ext make.

## Test plan
- Reset, then bytes 1C, F0 1C -> make ev_code=1C ev_ascii=0x61 press_cnt=1 held=1 held_code=0x01C; then break ev_make=0 held=0; ev_valid seen exactly twice.
- 12, 1C, 1C, F0 1C, F0 12 -> first 1C ascii=0x41 repeat=0; second 1C ev_repeat=1; press_cnt=2 (12 and 1C); shift=0 at end.
- 58, F0 58, 1C -> caps=1, ascii=0x41; then 12, 1C with caps=1 and shift=1 -> ascii=0x61.
- E0 75, E0 F0 75 -> make ev_ext=1 ev_code=75 ev_ascii=0; break ev_ext=1 held=0; no events on prefix bytes.
- Back-to-back in_valid every cycle with AA, FA, 16, E0, rst pulse, 16 -> AA and FA ignored; make 16 ascii=0x31; after rst all outputs 0; final 16 is a non-ext make with press_cnt=1.
- 256 distinct make/break pairs of 0x29 -> press_cnt wraps to 0; ascii=0x20 on each make.
